// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting the I-cache or D-cache exclusive use of the
// single-ported main memory for a fixed-latency line read or write-back.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned LINE_WIDTH       = 128,
  parameter int unsigned MEM_DELAY_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_resp,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_resp,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MEM_DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_DELAY_CYCLES - 1);
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;
  localparam logic SINGLE_CYCLE = (MEM_DELAY_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic                  last_q, last_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  ic_resp_q, ic_resp_d;
  logic                  dc_resp_q, dc_resp_d;
  logic [LINE_WIDTH-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_WIDTH-1:0] dc_rdata_q, dc_rdata_d;
  logic                  pick_dc_c;

  // On a tie the requester that was not served last wins.
  assign pick_dc_c = dc_req & (~ic_req | (last_q == GNT_IC));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= GNT_IC;
      we_q        <= 1'b0;
      last_q      <= GNT_IC;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_resp_q   <= 1'b0;
      dc_resp_q   <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      last_q      <= last_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_resp_q   <= ic_resp_d;
      dc_resp_q   <= dc_resp_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
    end
  end

  // Memory-side strobes are computed one cycle ahead so every output is a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    last_d      = last_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_resp_d   = 1'b0;
    dc_resp_d   = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;

    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          state_d    = BUSY;
          cnt_d      = CNT_LOAD;
          gnt_d      = pick_dc_c ? GNT_DC : GNT_IC;
          we_d       = pick_dc_c & dc_we;
          mem_addr_d = pick_dc_c ? dc_addr : ic_addr;
          if (pick_dc_c) begin
            mem_wdata_d = dc_wdata;
          end
          mem_en_d   = 1'b1;
          mem_we_d   = pick_dc_c & dc_we & SINGLE_CYCLE;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!we_q) begin
            if (gnt_q == GNT_DC) begin
              dc_rdata_d = mem_rdata;
            end else begin
              ic_rdata_d = mem_rdata;
            end
          end
          ic_resp_d = (gnt_q == GNT_IC);
          dc_resp_d = (gnt_q == GNT_DC);
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
          mem_we_d = we_q & (cnt_q == CNT_W'(1));
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ic_resp   = ic_resp_q;
  assign dc_resp   = dc_resp_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against
// a transaction-timing reference model and a shadow memory image.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;
  localparam int          N  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ic_req, ic_resp, dc_req, dc_we, dc_resp, mem_en, mem_we;
  logic [AW-1:0] ic_addr, dc_addr, mem_addr;
  logic [LW-1:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;

  logic          ic1_req, ic1_resp, dc1_resp, mem1_en, mem1_we;
  logic [AW-1:0] ic1_addr, mem1_addr;
  logic [LW-1:0] ic1_rdata, dc1_rdata, mem1_wdata, mem1_rdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_DELAY_CYCLES(N)) u_dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_resp(ic_resp), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_resp(dc_resp), .dc_rdata(dc_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_DELAY_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ic_req(ic1_req), .ic_addr(ic1_addr), .ic_resp(ic1_resp), .ic_rdata(ic1_rdata),
    .dc_req(1'b0), .dc_we(1'b0), .dc_addr('0), .dc_wdata('0),
    .dc_resp(dc1_resp), .dc_rdata(dc1_rdata),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_rdata(mem1_rdata)
  );

  // Physical memory: combinational read, write on mem_we, plus a preload port.
  logic [LW-1:0] phys [256];
  logic          bd_we;
  logic [7:0]    bd_idx;
  logic [LW-1:0] bd_data;
  assign mem_rdata  = phys[mem_addr[11:4]];
  assign mem1_rdata = {4{mem1_addr ^ 32'h5a5a_0000}};
  always @(posedge clk) begin
    if (bd_we) phys[bd_idx] <= bd_data;
    else if (mem_en && mem_we) phys[mem_addr[11:4]] <= mem_wdata;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: one transaction in flight, described by its start cycle.
  logic [LW-1:0] ref_mem [256];
  logic          m_act, m_win, m_we, m_last;
  int            m_start;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_rd, exp_ic, exp_dc;
  int            ic_rc, dc_rc, we_cnt, we_cyc;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return {20'h0, 8'($urandom), 4'h0};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_act  = 1'b0;
    m_last = 1'b0;
    exp_ic = '0;
    exp_dc = '0;
  endtask

  task automatic model_check();
    logic busy, rsp, last_busy;
    logic [7:0] idx;
    if (m_act && cyc > m_start + N + 1) m_act = 1'b0;
    busy      = m_act && cyc >= m_start + 1 && cyc <= m_start + N;
    last_busy = m_act && cyc == m_start + N;
    rsp       = m_act && cyc == m_start + N + 1;
    idx       = m_addr[11:4];
    if (last_busy) begin
      if (m_we) ref_mem[idx] = m_wdata;
      else m_rd = ref_mem[idx];
    end
    if (rsp) begin
      m_last = m_win;
      if (!m_we) begin
        if (m_win) exp_dc = m_rd;
        else exp_ic = m_rd;
      end
    end
    check("ic_resp", LW'(ic_resp), LW'(rsp && !m_win));
    check("dc_resp", LW'(dc_resp), LW'(rsp && m_win));
    check("mem_en", LW'(mem_en), LW'(busy));
    check("mem_we", LW'(mem_we), LW'(last_busy && m_we));
    check("ic_rdata", ic_rdata, exp_ic);
    check("dc_rdata", dc_rdata, exp_dc);
    if (busy) check("mem_addr", LW'(mem_addr), LW'(m_addr));
    if (busy && m_we) check("mem_wdata", mem_wdata, m_wdata);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ic_resp) ic_rc = cyc;
    if (dc_resp) dc_rc = cyc;
    if (mem_we) begin
      we_cnt++;
      we_cyc = cyc;
    end
    model_check();
  endtask

  task automatic decide();
    if (!rst && !m_act && (ic_req || dc_req)) begin
      m_win   = dc_req && (!ic_req || !m_last);
      m_act   = 1'b1;
      m_start = cyc;
      m_addr  = m_win ? dc_addr : ic_addr;
      m_we    = m_win && dc_we;
      m_wdata = dc_wdata;
    end
  endtask

  // One cycle of traffic; gen enables random new requests from idle requesters.
  task automatic run(input int n, input bit gen);
    for (int i = 0; i < n; i++) begin
      step();
      if (ic_resp) ic_req = 1'b0;
      else if (gen && !ic_req && $urandom_range(0, 3) == 0) begin
        ic_req  = 1'b1;
        ic_addr = rand_addr();
      end
      if (dc_resp) dc_req = 1'b0;
      else if (gen && !dc_req && $urandom_range(0, 3) == 0) begin
        dc_req   = 1'b1;
        dc_we    = 1'($urandom);
        dc_addr  = rand_addr();
        dc_wdata = rand_line();
      end
      if (m_act && m_win && cyc >= m_start + 1 && cyc <= m_start + N) begin
        dc_addr  = rand_addr();
        dc_wdata = rand_line();
        dc_we    = 1'($urandom);
      end
      decide();
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ic_req  = 1'b0;
    dc_req  = 1'b0;
    ic1_req = 1'b0;
    model_reset();
    step();
    step();
    check("rst_addr", LW'(mem_addr), '0);
    check("rst_wdata", mem_wdata, '0);
    rst = 1'b0;
  endtask

  localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] WB_DAT = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;

  initial begin
    int t0;
    int nmis;
    rst = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; ic1_req = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; ic1_addr = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    for (int i = 0; i < 256; i++) begin
      bd_we   = 1'b1;
      bd_idx  = 8'(i);
      bd_data = (i == 8'h80) ? PAT_A5 : rand_line();
      ref_mem[i] = bd_data;
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;
    do_reset();

    // Single I-cache read of 0x800.
    ic_rc = -1; dc_rc = -1; we_cnt = 0;
    t0 = cyc; ic_req = 1'b1; ic_addr = 32'h800; decide();
    run(8, 1'b0);
    check("ic_lat", LW'(ic_rc), LW'(t0 + 6));
    check("ic_data", ic_rdata, PAT_A5);
    check("ic_no_dc", LW'(dc_rc), LW'(-1));
    check("ic_no_we", LW'(we_cnt), '0);

    // D-cache write-back of 0x3000, live inputs scrambled while busy, then read back.
    t0 = cyc; dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h3000; dc_wdata = WB_DAT; decide();
    run(8, 1'b0);
    check("wb_we_cnt", LW'(we_cnt), LW'(1));
    check("wb_we_cyc", LW'(we_cyc), LW'(t0 + 5));
    check("wb_lat", LW'(dc_rc), LW'(t0 + 6));
    check("wb_rdata", dc_rdata, '0);
    t0 = cyc; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h3000; decide();
    run(8, 1'b0);
    check("rb_lat", LW'(dc_rc), LW'(t0 + 6));
    check("rb_data", dc_rdata, WB_DAT);

    // Tie straight after reset, then a lone D-cache request, then another tie.
    do_reset();
    t0 = cyc; ic_req = 1; ic_addr = 32'h0400; dc_req = 1; dc_we = 0; dc_addr = 32'h0500; decide();
    run(14, 1'b0);
    check("tie1_dc", LW'(dc_rc), LW'(t0 + 6));
    check("tie1_ic", LW'(ic_rc), LW'(t0 + 13));
    dc_req = 1; dc_we = 0; dc_addr = 32'h0600; decide();
    run(8, 1'b0);
    t0 = cyc; ic_req = 1; ic_addr = 32'h0700; dc_req = 1; dc_we = 0; dc_addr = 32'h0900; decide();
    run(14, 1'b0);
    check("tie2_ic", LW'(ic_rc), LW'(t0 + 6));
    check("tie2_dc", LW'(dc_rc), LW'(t0 + 13));

    // Reset in BUSY cycle 3 of a write-back.
    we_cnt = 0; dc_rc = -1;
    t0 = cyc; dc_req = 1; dc_we = 1; dc_addr = 32'h1230; dc_wdata = rand_line(); decide();
    run(3, 1'b0);
    check("rb3_cyc", LW'(cyc), LW'(t0 + 3));
    rst = 1'b1; dc_req = 1'b0; model_reset();
    step();
    check("rab_addr", LW'(mem_addr), '0);
    check("rab_wdata", mem_wdata, '0);
    rst = 1'b0;
    run(10, 1'b0);
    check("rab_we", LW'(we_cnt), '0);
    check("rab_resp", LW'(dc_rc), LW'(-1));
    check("rab_mem", phys[8'h23], ref_mem[8'h23]);

    // Single-cycle-latency instance: resp in cycle 2, next request accepted in cycle 3.
    t0 = cyc; ic1_req = 1'b1; ic1_addr = 32'h0000_0AB0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("d1_en", LW'(mem1_en), LW'(k == 1 || k == 4));
      check("d1_resp", LW'(ic1_resp), LW'(k == 2 || k == 5));
      check("d1_we", LW'(mem1_we | dc1_resp), '0);
      if (k == 2) check("d1_data_a", ic1_rdata, {4{32'h0000_0AB0 ^ 32'h5a5a_0000}});
      if (k == 4) check("d1_addr_b", LW'(mem1_addr), LW'(32'h0000_0CD0));
      if (k == 5) check("d1_data_b", ic1_rdata, {4{32'h0000_0CD0 ^ 32'h5a5a_0000}});
      if (ic1_resp) ic1_req = 1'b0;
      if (k == 3) begin
        ic1_req  = 1'b1;
        ic1_addr = 32'h0000_0CD0;
      end
    end
    check("d1_dc_idle", dc1_rdata | mem1_wdata, '0);

    // Random traffic from both caches.
    run(1500, 1'b1);
    ic_req = 1'b0;
    dc_req = 1'b0;
    run(3 * (N + 2), 1'b0);
    nmis = 0;
    for (int i = 0; i < 256; i++) if (phys[i] !== ref_mem[i]) nmis++;
    check("mem_image", LW'(nmis), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
